// File: rtl/speck_pkg.sv
// speck_pkg: shared SPECK128/128 key-schedule constants and FSM encoding
package speck_pkg;
  localparam int WORD_W    = 64;
  localparam int KEY_W     = 2 * WORD_W;
  localparam int NR_ROUNDS = 32;
  localparam int ALPHA     = 8;
  localparam int BETA      = 3;
  typedef enum logic [1:0] {IDLE, EXPAND, LOADED, STREAM} state_e;
endpackage

// File: rtl/speck_key_step.sv
// speck_key_step: one combinational SPECK key-schedule step (k, l, i) -> (k', l')
module speck_key_step
  import speck_pkg::*;
#(
  parameter int W  = WORD_W,
  parameter int IW = 5
) (
  input  logic [W-1:0]  k_i,
  input  logic [W-1:0]  l_i,
  input  logic [IW-1:0] i_i,
  output logic [W-1:0]  k_o,
  output logic [W-1:0]  l_o
);
  assign l_o = (k_i + {l_i[ALPHA-1:0], l_i[W-1:ALPHA]}) ^ W'(i_i);
  assign k_o = {k_i[W-BETA-1:0], k_i[W-1:W-BETA]} ^ l_o;
endmodule

// File: rtl/speck_round_key_buffer.sv
// speck_round_key_buffer: expands a SPECK128/128 key into a round-key file and streams it forward or reverse
module speck_round_key_buffer #(
  parameter int NR_ROUNDS = 32,
  parameter int WORD_W    = 64,
  parameter int IDX_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*WORD_W-1:0]   key_in,
  input  logic                  key_in_valid,
  output logic                  key_in_ready,
  input  logic                  stream_req,
  input  logic                  stream_dir,
  output logic                  keys_valid,
  output logic                  busy,
  output logic [WORD_W-1:0]     rk_data,
  output logic [IDX_W-1:0]      rk_idx,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic                  rk_last
);
  import speck_pkg::*;
  state_e              state_q;
  logic [WORD_W-1:0]   rf_q [NR_ROUNDS];
  logic [WORD_W-1:0]   k_q, l_q, k_d, l_d, rk_data_q;
  logic [IDX_W-1:0]    i_q, rk_idx_q, nxt_idx, start_idx;
  logic                dir_q, rk_last_q, load;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ROUNDS - 1);
  assign load      = (state_q == IDLE || state_q == LOADED) && key_in_valid;
  assign start_idx = stream_dir ? LAST_IDX : '0;
  assign nxt_idx   = dir_q ? rk_idx_q - 1'b1 : rk_idx_q + 1'b1;
  speck_key_step #(.W(WORD_W), .IW(IDX_W)) u_step (
    .k_i(k_q),
    .l_i(l_q),
    .i_i(i_q),
    .k_o(k_d),
    .l_o(l_d)
  );
  // round-key file: k0 written on load, k_{i+1} written on every expansion step
  always_ff @(posedge clk)
    if (load) rf_q[0] <= key_in[WORD_W-1:0];
    else if (state_q == EXPAND) rf_q[i_q + 1'b1] <= k_d;
  // control FSM with registered stream beat (data, index, last flag)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      l_q       <= '0;
      i_q       <= '0;
      dir_q     <= 1'b0;
      rk_data_q <= '0;
      rk_idx_q  <= '0;
      rk_last_q <= 1'b0;
    end else if (load) begin
      state_q <= EXPAND;
      k_q     <= key_in[WORD_W-1:0];
      l_q     <= key_in[2*WORD_W-1:WORD_W];
      i_q     <= '0;
    end else if (state_q == EXPAND) begin
      k_q <= k_d;
      l_q <= l_d;
      i_q <= i_q + 1'b1;
      if (i_q == IDX_W'(NR_ROUNDS - 2)) state_q <= LOADED;
    end else if (state_q == LOADED && stream_req) begin
      state_q   <= STREAM;
      dir_q     <= stream_dir;
      rk_idx_q  <= start_idx;
      rk_data_q <= rf_q[start_idx];
      rk_last_q <= stream_dir ? start_idx == '0 : start_idx == LAST_IDX;
    end else if (state_q == STREAM && rk_ready) begin
      if (rk_last_q) begin
        state_q   <= LOADED;
        rk_data_q <= '0;
        rk_idx_q  <= '0;
        rk_last_q <= 1'b0;
      end else begin
        rk_idx_q  <= nxt_idx;
        rk_data_q <= rf_q[nxt_idx];
        rk_last_q <= dir_q ? nxt_idx == '0 : nxt_idx == LAST_IDX;
      end
    end
  assign key_in_ready = state_q == IDLE || state_q == LOADED;
  assign busy         = state_q == EXPAND || state_q == STREAM;
  assign keys_valid   = state_q == LOADED || state_q == STREAM;
  assign rk_valid     = state_q == STREAM;
  assign rk_data      = rk_data_q;
  assign rk_idx       = rk_idx_q;
  assign rk_last      = rk_last_q;
endmodule
